// File: rtl/or1200_fwd_pkg.sv
// Shared definitions for the operand-forwarding control slice.
//   aw, SEL_WIDTH          : register address / mux select widths
//   SEL_*                  : operand mux select encodings
//   slot_t                 : one pipeline slot's write-back descriptor
//   slot_hit()             : does a slot forward to a given source address
package or1200_fwd_pkg;
  localparam int aw        = 5;
  localparam int SEL_WIDTH = 2;
  localparam int NUM_OPS   = 2;

  typedef logic [SEL_WIDTH-1:0] sel_t;
  typedef logic [aw-1:0]        addr_t;

  localparam sel_t SEL_RF      = 2'd0;
  localparam sel_t SEL_IMM     = 2'd1;
  localparam sel_t SEL_EX_FORW = 2'd2;
  localparam sel_t SEL_WB_FORW = 2'd3;

  typedef struct packed {
    logic  rfwb;
    addr_t rf_addrw;
  } slot_t;

  // r0 is hardwired to zero, so it is never a forwarding source.
  function automatic logic slot_hit(input slot_t s, input addr_t a);
    return s.rfwb && (s.rf_addrw == a) && (a != '0);
  endfunction
endpackage

// File: rtl/or1200_fwd_cmp.sv
// Per-operand hazard comparator (purely combinational).
//   src     : source register address of the incoming instruction
//   imm     : operand is the immediate (only ever set on the B operand)
//   id_slot : producer currently in ID (becomes EX next cycle)
//   ex_slot : producer currently in EX (becomes WB next cycle)
//   sel     : select to register for the coming ID cycle
module or1200_fwd_cmp
  import or1200_fwd_pkg::*;
(
  input  addr_t src,
  input  logic  imm,
  input  slot_t id_slot,
  input  slot_t ex_slot,
  output sel_t  sel
);
  // The slots shift one stage on the same edge the select is captured, so
  // an ID-slot producer is read from EX, and an EX-slot producer from WB.
  // The ID slot is the youngest producer and therefore wins ties.
  always_comb begin
    sel = SEL_RF;
    if (imm)                          sel = SEL_IMM;
    else if (slot_hit(id_slot, src))  sel = SEL_EX_FORW;
    else if (slot_hit(ex_slot, src))  sel = SEL_WB_FORW;
  end
endmodule

// File: rtl/or1200_fwd_ctrl.sv
// Forwarding control: tracks write-back destinations through the ID, EX
// and WB slots and registers operand mux selects at the IF->ID edge.
//   clk, rst                    : core clock, async active-high reset
//   id/ex/wb_freeze             : per-stage hold
//   flushpipe                   : kill ID and EX contents
//   if_rfa_addr/if_rfb_addr     : sources of the instruction entering ID
//   if_imm_b                    : entering instruction uses immediate for B
//   if_rfwb/if_rf_addrw         : destination of the entering instruction
//   sel_a/sel_b                 : registered operand mux selects
//   {id,ex,wb}_rfwb/_rf_addrw   : slot write enable and destination
module or1200_fwd_ctrl
  import or1200_fwd_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          id_freeze,
  input  logic          ex_freeze,
  input  logic          wb_freeze,
  input  logic          flushpipe,
  input  logic [aw-1:0] if_rfa_addr,
  input  logic [aw-1:0] if_rfb_addr,
  input  logic          if_imm_b,
  input  logic          if_rfwb,
  input  logic [aw-1:0] if_rf_addrw,
  output logic [1:0]    sel_a,
  output logic [1:0]    sel_b,
  output logic          id_rfwb,
  output logic [aw-1:0] id_rf_addrw,
  output logic          ex_rfwb,
  output logic [aw-1:0] ex_rf_addrw,
  output logic          wb_rfwb,
  output logic [aw-1:0] wb_rf_addrw
);
  slot_t id_slot, ex_slot, wb_slot;
  sel_t  sel_q   [NUM_OPS];
  sel_t  sel_nx  [NUM_OPS];

  // A later stage frozen forces the earlier ones to hold too, so a
  // malformed freeze combination degrades to a consistent stall.
  logic wb_frz, ex_frz, id_frz;
  assign wb_frz = wb_freeze;
  assign ex_frz = ex_freeze | wb_frz;
  assign id_frz = id_freeze | ex_frz;

  logic [NUM_OPS-1:0][aw-1:0] src;
  logic [NUM_OPS-1:0]         imm;
  assign src = {if_rfb_addr, if_rfa_addr};
  assign imm = {if_imm_b, 1'b0};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    or1200_fwd_cmp u_cmp (
      .src     (src[i]),
      .imm     (imm[i]),
      .id_slot (id_slot),
      .ex_slot (ex_slot),
      .sel     (sel_nx[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_slot <= '0;
      ex_slot <= '0;
      wb_slot <= '0;
      for (int i = 0; i < NUM_OPS; i++) sel_q[i] <= SEL_RF;
    end else begin
      // ID slot
      if (!id_frz) begin
        id_slot.rf_addrw <= if_rf_addrw;
        id_slot.rfwb     <= if_rfwb && (if_rf_addrw != '0);
      end
      if (flushpipe) id_slot.rfwb <= 1'b0;

      // EX slot: bubble when ID is stalled but EX advances
      if (!ex_frz) begin
        if (id_frz) ex_slot.rfwb <= 1'b0;
        else        ex_slot      <= id_slot;
      end
      if (flushpipe) ex_slot.rfwb <= 1'b0;

      // WB slot: not affected by flush
      if (!wb_frz) begin
        if (ex_frz) wb_slot.rfwb <= 1'b0;
        else        wb_slot      <= ex_slot;
      end

      // Selects
      for (int i = 0; i < NUM_OPS; i++) begin
        if (flushpipe)    sel_q[i] <= SEL_RF;
        else if (!id_frz) sel_q[i] <= sel_nx[i];
      end
    end
  end

  assign sel_a       = sel_q[0];
  assign sel_b       = sel_q[1];
  assign id_rfwb     = id_slot.rfwb;
  assign id_rf_addrw = id_slot.rf_addrw;
  assign ex_rfwb     = ex_slot.rfwb;
  assign ex_rf_addrw = ex_slot.rf_addrw;
  assign wb_rfwb     = wb_slot.rfwb;
  assign wb_rf_addrw = wb_slot.rf_addrw;
endmodule

// File: doc/or1200_fwd_ctrl.md
Name: or1200_fwd_ctrl

Overview:
Upstream neighbour of the operand mux stage. Tracks register-file write-back destinations through the ID, EX and WB pipeline slots, honouring the per-stage freeze and flush signals. At the IF->ID transfer edge it compares the incoming instruction's source register addresses against in-flight destinations. It produces registered sel_a/sel_b, which drive the operand muxes combinationally during ID.

Parameters:
aw, 5, register-file address width
SEL_WIDTH, 2, mux select width (from shared package)

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-high
id_freeze  in  1  hold ID stage
ex_freeze  in  1  hold EX stage
wb_freeze  in  1  hold WB stage
flushpipe  in  1  kill instructions in ID and EX
if_rfa_addr  in  aw  source A address of instruction entering ID
if_rfb_addr  in  aw  source B address of instruction entering ID
if_imm_b  in  1  instruction entering ID uses immediate as operand B
if_rfwb  in  1  instruction entering ID writes the register file
if_rf_addrw  in  aw  destination of instruction entering ID
sel_a  out  2  operand A select (RF/EX_FORW/WB_FORW)
sel_b  out  2  operand B select (RF/IMM/EX_FORW/WB_FORW)
id_rfwb, id_rf_addrw  out  1, aw  ID-slot write enable/destination
ex_rfwb, ex_rf_addrw  out  1, aw  EX-slot write enable/destination
wb_rfwb, wb_rf_addrw  out  1, aw  WB-slot write enable/destination

Behaviour:
- Select encoding: SEL_RF=2'd0, SEL_IMM=2'd1, SEL_EX_FORW=2'd2, SEL_WB_FORW=2'd3. sel_a never equals SEL_IMM.
- Reset (rst=1, async): all outputs are 0. sel_a=sel_b=SEL_RF, all rfwb=0, all addrw=0. Reset mid-stall discards all slot state.
- ID slot, on posedge when !id_freeze: id_rfwb<=if_rfwb, id_rf_addrw<=if_rf_addrw. A write with destination 0 is stored with rfwb forced to 0, because r0 is never written or forwarded.
- EX slot, on posedge when !ex_freeze: if id_freeze, insert a bubble (ex_rfwb<=0, addrw held). Otherwise copy the ID slot.
- WB slot, on posedge when !wb_freeze: if ex_freeze, insert a bubble (wb_rfwb<=0). Otherwise copy the EX slot.
- flushpipe (synchronous, highest priority after reset): next edge sets id_rfwb<=0 and ex_rfwb<=0, and sel_a=sel_b=SEL_RF. The WB slot updates normally.
- Select generation, on posedge when !id_freeze and !flushpipe, using pre-edge slot contents:
  - Operand A: if id_rfwb && id_rf_addrw==if_rfa_addr && if_rfa_addr!=0, select SEL_EX_FORW. Else if ex_rfwb && ex_rf_addrw==if_rfa_addr && if_rfa_addr!=0, select SEL_WB_FORW. Else SEL_RF.
  - Operand B: if_imm_b selects SEL_IMM first. Otherwise the same priority chain as A, using if_rfb_addr.
  - Both ID and EX match: EX_FORW wins, because it is the youngest producer.
- When id_freeze=1, sel_a/sel_b hold. Operand capture during stalls is the operand mux stage's job.
- Latency: one cycle from IF-side addresses to sel outputs. No combinational input->output path.
- Freeze ordering: wb_freeze implies ex_freeze implies id_freeze. When ex_freeze=1 and id_freeze=0, the block behaves as if id_freeze=1; no assertion fires.

Decomposition:
- Shared package or1200_fwd_pkg holds the SEL_* constants, SEL_WIDTH, aw, and a slot struct {rfwb, rf_addrw}.
- One sub-module, or1200_fwd_cmp, is natural. It takes a source address, the ID slot and the EX slot, and returns a 2-bit select. It is instantiated twice; the B instance has an imm override input.

Test Plan:
1. Reset asserted mid-stream with slots full -> all outputs 0 immediately, without waiting for a clock edge.
2. Back-to-back dependent instructions:
   - Cycle 0: if_rfwb=1, if_rf_addrw=5.
   - Cycle 1: if_rfa_addr=5.
   - Required: sel_a=2'd2 after the cycle-1 edge.
   - One unrelated instruction later, if_rfb_addr=5 -> sel_b=2'd3.
3. Source address 0 with a producer to r0 in ID -> sel_a=2'd0; id_rfwb=0.
4. if_imm_b=1 with if_rfb_addr matching the ID destination -> sel_b=2'd1.
5. id_freeze=1 and ex_freeze=0 for 2 cycles:
   - ex_rfwb=0 (bubble) on the next edge.
   - sel_a/sel_b unchanged throughout.
   - After release, a producer that has moved to WB is not forwarded, and a producer in EX yields WB_FORW.
6. flushpipe pulse with a matching producer in ID -> next edge: id_rfwb=ex_rfwb=0 and sel_a=sel_b=2'd0. The following dependent instruction gets SEL_RF.
